// File: rtl/card_deal_scheduler.sv
// Round-robin arbiter sharing one card generator between player, split and dealer hands.
// Each grant pulses gen_on once, waits GEN_LAT cycles, then returns one or two captured cards.
module card_deal_scheduler #(
   parameter int GEN_LAT = 1,
   parameter int CARD_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        req,
   input  logic [2:0]        pair,
   input  logic              hold,
   input  logic              round_clr,
   output logic [2:0]        gnt,
   output logic              gen_on,
   input  logic [CARD_W-1:0] gen_card1,
   input  logic [CARD_W-1:0] gen_card2,
   output logic [2:0]        card_valid,
   output logic [CARD_W-1:0] card_a,
   output logic [CARD_W-1:0] card_b,
   output logic              busy,
   output logic [7:0]        deal_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

   state_t            state_reg, state_next;
   logic [1:0]        last_reg, last_next;
   logic [1:0]        win_reg, win_next;
   logic              pair_l_reg, pair_l_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic [2:0]        gnt_reg, gnt_next;
   logic              gen_on_reg, gen_on_next;
   logic [2:0]        cv_reg, cv_next;
   logic [CARD_W-1:0] card_a_reg, card_a_next;
   logic [CARD_W-1:0] card_b_reg, card_b_next;
   logic              busy_reg, busy_next;
   logic [7:0]        count_reg, count_next;

   // cand[0] is the highest-priority requester: the one just after the last winner
   logic [1:0] cand [3];
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_rot
         logic [2:0] rot_sum;
         assign rot_sum  = {1'b0, last_reg} + 3'(gi + 1);
         assign cand[gi] = (rot_sum >= 3'd3) ? 2'(rot_sum - 3'd3) : rot_sum[1:0];
      end
   endgenerate

   logic [1:0] win_idx;
   always_comb begin
      win_idx = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         if (req[cand[k]]) win_idx = cand[k];
      end
   end

   always_comb begin
      state_next  = state_reg;
      last_next   = last_reg;
      win_next    = win_reg;
      pair_l_next = pair_l_reg;
      cnt_next    = cnt_reg;
      gnt_next    = 3'b000;
      gen_on_next = 1'b0;
      cv_next     = 3'b000;
      card_a_next = card_a_reg;
      card_b_next = card_b_reg;
      count_next  = count_reg;
      case (state_reg)
         IDLE: begin
            if (!hold && (req != 3'b000)) begin
               win_next    = win_idx;
               pair_l_next = pair[win_idx];
               gnt_next    = 3'b001 << win_idx;
               gen_on_next = 1'b1;
               state_next  = ISSUE;
            end
         end
         ISSUE: begin
            cnt_next   = 4'(GEN_LAT);
            state_next = WAIT;
         end
         WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
               card_a_next = gen_card1;
               card_b_next = pair_l_reg ? gen_card2 : '0;
               cv_next     = 3'b001 << win_reg;
               state_next  = DELIVER;
            end
         end
         DELIVER: begin
            last_next  = win_reg;
            count_next = count_reg + (pair_l_reg ? 8'd2 : 8'd1);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // A round clear overrides a coincident delivery update
      if (round_clr) begin
         count_next = 8'd0;
         last_next  = 2'd2;
      end
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         last_reg   <= 2'd2;
         win_reg    <= 2'd0;
         pair_l_reg <= 1'b0;
         cnt_reg    <= 4'd0;
         gnt_reg    <= 3'b000;
         gen_on_reg <= 1'b0;
         cv_reg     <= 3'b000;
         card_a_reg <= '0;
         card_b_reg <= '0;
         busy_reg   <= 1'b0;
         count_reg  <= 8'd0;
      end else begin
         state_reg  <= state_next;
         last_reg   <= last_next;
         win_reg    <= win_next;
         pair_l_reg <= pair_l_next;
         cnt_reg    <= cnt_next;
         gnt_reg    <= gnt_next;
         gen_on_reg <= gen_on_next;
         cv_reg     <= cv_next;
         card_a_reg <= card_a_next;
         card_b_reg <= card_b_next;
         busy_reg   <= busy_next;
         count_reg  <= count_next;
      end
   end

   assign gnt        = gnt_reg;
   assign gen_on     = gen_on_reg;
   assign card_valid = cv_reg;
   assign card_a     = card_a_reg;
   assign card_b     = card_b_reg;
   assign busy       = busy_reg;
   assign deal_count = count_reg;

endmodule

// File: tb/tb_card_deal_scheduler.sv
// Directed bench for card_deal_scheduler: vector table plus hand-written multi-cycle sequences.
module tb_card_deal_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] req, pair;
   logic       hold, round_clr;
   logic [2:0] gnt, card_valid;
   logic       gen_on, busy;
   logic [3:0] gen_card1, gen_card2, card_a, card_b;
   logic [7:0] deal_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   card_deal_scheduler #(.GEN_LAT(1), .CARD_W(4)) dut (
      .clk(clk), .reset(reset), .req(req), .pair(pair), .hold(hold),
      .round_clr(round_clr), .gnt(gnt), .gen_on(gen_on),
      .gen_card1(gen_card1), .gen_card2(gen_card2), .card_valid(card_valid),
      .card_a(card_a), .card_b(card_b), .busy(busy), .deal_count(deal_count)
   );

   typedef struct {
      logic [2:0] req, pair;
      logic       hold, clr;
      logic [3:0] g1, g2;
      logic [2:0] egnt;
      logic       egen;
      logic [2:0] ecv;
      logic [3:0] ea, eb;
      logic       ebusy;
      logic [7:0] ecnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [2:0] r, logic [2:0] p, logic h, logic c,
                               logic [3:0] g1, logic [3:0] g2, logic [2:0] egnt,
                               logic egen, logic [2:0] ecv, logic [3:0] ea,
                               logic [3:0] eb, logic ebusy, logic [7:0] ecnt);
      vec_t v;
      v.req = r; v.pair = p; v.hold = h; v.clr = c; v.g1 = g1; v.g2 = g2;
      v.egnt = egnt; v.egen = egen; v.ecv = ecv; v.ea = ea; v.eb = eb;
      v.ebusy = ebusy; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One complete deal; optionally pulses round_clr during the DELIVER cycle
   task automatic deal(input logic [2:0] r, input logic [2:0] p, input bit clr_at_deliver);
      int n;
      req = r; pair = p;
      n = 0;
      do begin step(); n++; end while (gnt == 3'b000 && n < 20);
      chk("deal_gnt", gnt, r);
      req = 3'b000;
      n = 0;
      do begin step(); n++; end while (card_valid == 3'b000 && n < 20);
      chk("deal_cv", card_valid, r);
      if (clr_at_deliver) round_clr = 1'b1;
      step();
      round_clr = 1'b0;
   endtask

   initial begin
      int gcyc[3];
      logic [2:0] gord[3];
      int ng;
      bit cv_seen, overlap;

      reset = 1'b1; req = 3'b000; pair = 3'b000; hold = 1'b0; round_clr = 1'b0;
      gen_card1 = 4'd0; gen_card2 = 4'd0;
      step(); step();
      chk("rst_gnt", gnt, 0);
      chk("rst_gen_on", gen_on, 0);
      chk("rst_cv", card_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", deal_count, 0);
      reset = 1'b0;

      // single deal to player, pair deal to dealer, then hold gating
      vecs.push_back(mk(3'b001, 3'b000, 0, 0, 7, 3, 3'b001, 1, 3'b000, 0, 0, 1, 0));
      vecs.push_back(mk(3'b000, 3'b000, 0, 0, 7, 3, 3'b000, 0, 3'b000, 0, 0, 1, 0));
      vecs.push_back(mk(3'b000, 3'b000, 0, 0, 7, 3, 3'b000, 0, 3'b001, 7, 0, 1, 0));
      vecs.push_back(mk(3'b000, 3'b000, 0, 0, 7, 3, 3'b000, 0, 3'b000, 7, 0, 0, 1));
      vecs.push_back(mk(3'b100, 3'b100, 0, 0, 10, 1, 3'b100, 1, 3'b000, 7, 0, 1, 1));
      vecs.push_back(mk(3'b000, 3'b000, 0, 0, 10, 1, 3'b000, 0, 3'b000, 7, 0, 1, 1));
      vecs.push_back(mk(3'b000, 3'b000, 0, 0, 10, 1, 3'b000, 0, 3'b100, 10, 1, 1, 1));
      vecs.push_back(mk(3'b000, 3'b000, 0, 0, 10, 1, 3'b000, 0, 3'b000, 10, 1, 0, 3));
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk(3'b010, 3'b000, 1, 0, 5, 6, 3'b000, 0, 3'b000, 10, 1, 0, 3));
      vecs.push_back(mk(3'b010, 3'b000, 0, 0, 5, 6, 3'b010, 1, 3'b000, 10, 1, 1, 3));
      vecs.push_back(mk(3'b000, 3'b000, 0, 0, 5, 6, 3'b000, 0, 3'b000, 10, 1, 1, 3));
      vecs.push_back(mk(3'b000, 3'b000, 0, 0, 5, 6, 3'b000, 0, 3'b010, 5, 0, 1, 3));
      vecs.push_back(mk(3'b000, 3'b000, 0, 0, 5, 6, 3'b000, 0, 3'b000, 5, 0, 0, 4));

      foreach (vecs[i]) begin
         req = vecs[i].req; pair = vecs[i].pair; hold = vecs[i].hold;
         round_clr = vecs[i].clr; gen_card1 = vecs[i].g1; gen_card2 = vecs[i].g2;
         step();
         $display("vec %0d: req=%b gnt=%b gen_on=%b cv=%b a=%0d b=%0d busy=%b count=%0d",
                  i, vecs[i].req, gnt, gen_on, card_valid, card_a, card_b, busy, deal_count);
         chk("vec_gnt", gnt, vecs[i].egnt);
         chk("vec_gen_on", gen_on, vecs[i].egen);
         chk("vec_cv", card_valid, vecs[i].ecv);
         chk("vec_card_a", card_a, vecs[i].ea);
         chk("vec_card_b", card_b, vecs[i].eb);
         chk("vec_busy", busy, vecs[i].ebusy);
         chk("vec_count", deal_count, vecs[i].ecnt);
      end
      hold = 1'b0;

      // round-robin with all three requesting from reset
      reset = 1'b1; req = 3'b111; pair = 3'b000; gen_card1 = 4'd9; gen_card2 = 4'd2;
      step(); step();
      reset = 1'b0;
      ng = 0; overlap = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         step();
         if ((gnt != 3'b000 && card_valid != 3'b000) || (gnt != 3'b000) != gen_on)
            overlap = 1;
         if (gnt != 3'b000 && ng < 3) begin
            gcyc[ng] = cyc; gord[ng] = gnt; ng++;
            req = req & ~gnt;
            $display("rr grant %0d: gnt=%b at cycle %0d", ng, gnt, cyc);
         end
      end
      chk("rr_ngrants", ng, 3);
      chk("rr_order0", gord[0], 3'b001);
      chk("rr_order1", gord[1], 3'b010);
      chk("rr_order2", gord[2], 3'b100);
      chk("rr_first_cyc", gcyc[0], 1);
      chk("rr_gap01", gcyc[1] - gcyc[0], 4);
      chk("rr_gap12", gcyc[2] - gcyc[1], 4);
      chk("rr_count", deal_count, 3);
      chk("rr_exclusive", overlap, 0);

      // reset during WAIT drops the deal
      req = 3'b001; pair = 3'b001;
      step();
      chk("rw_gnt", gnt, 3'b001);
      req = 3'b000;
      step();
      chk("rw_busy_wait", busy, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      $display("reset in wait: busy=%b a=%0d b=%0d cv=%b", busy, card_a, card_b, card_valid);
      chk("rw_busy", busy, 0);
      chk("rw_card_a", card_a, 0);
      chk("rw_card_b", card_b, 0);
      cv_seen = (card_valid != 3'b000);
      for (int i = 0; i < 6; i++) begin
         step();
         if (card_valid != 3'b000) cv_seen = 1;
      end
      chk("rw_no_cv", cv_seen, 0);
      chk("rw_count", deal_count, 0);

      // deal_count wrap and round_clr coincident with DELIVER
      for (int i = 0; i < 127; i++) deal(3'b010, 3'b010, 0);
      deal(3'b001, 3'b000, 0);
      $display("count before wrap: %0d", deal_count);
      chk("wrap_255", deal_count, 255);
      deal(3'b100, 3'b100, 0);
      $display("count after wrap: %0d", deal_count);
      chk("wrap_1", deal_count, 1);
      deal(3'b001, 3'b000, 1);
      $display("count after round_clr: %0d", deal_count);
      chk("clr_count", deal_count, 0);
      req = 3'b011; pair = 3'b000;
      step();
      chk("clr_last_prio", gnt, 3'b001);
      req = 3'b000;
      for (int i = 0; i < 4; i++) step();
      chk("end_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
